// File: rtl/riscv_pkg.sv
// Shared core definitions: the fetch FSM state type and fetch-stage constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, decode handshake, redirect and status.
interface fetch_unit_if;
  logic [31:0] imem_address;
  logic [31:0] imem_data_out;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_address, instr, instr_pc, instr_valid, fetch_fault, fetch_count,
    input  imem_data_out, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_address, instr, instr_pc, instr_valid, fetch_fault, fetch_count,
    output imem_data_out, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, reads instruction memory, presents words over
// valid/ready and accepts redirects from execute; misaligned targets lock into FAULT.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_instr_valid;
  logic         r_fetch_fault;
  logic [31:0]  r_fetch_count;

  logic w_accept;
  logic w_redirect;
  logic w_misaligned;
  logic w_capture;
  logic w_clear_valid;
  logic w_count_inc;
  logic w_set_fault;

  assign w_accept     = (r_state == HOLD) && r_instr_valid && bus.instr_ready;
  assign w_redirect   = bus.redirect_valid && (r_state != FAULT);
  assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    w_count_inc   = 1'b0;
    w_set_fault   = 1'b0;

    case (r_state)
      FETCH: w_state_next = WAIT;
      WAIT: begin
        w_capture    = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        if (w_accept) begin
          w_pc_next     = r_pc + PC_STEP;
          w_clear_valid = 1'b1;
          w_count_inc   = 1'b1;
          w_state_next  = FETCH;
        end
      end
      FAULT: w_state_next = FAULT;
      default: w_state_next = FETCH;
    endcase

    // Redirect overrides the state walk; an accept in the same HOLD cycle still counts.
    if (w_redirect) begin
      w_capture     = 1'b0;
      w_clear_valid = 1'b1;
      w_count_inc   = w_accept;
      if (w_misaligned) begin
        w_pc_next    = r_pc;
        w_set_fault  = 1'b1;
        w_state_next = FAULT;
      end else begin
        w_pc_next    = bus.redirect_pc;
        w_state_next = FETCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_capture) begin
        r_instr       <= bus.imem_data_out;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end else if (w_clear_valid) begin
        r_instr_valid <= 1'b0;
      end
      if (w_count_inc) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_set_fault) r_fetch_fault <= 1'b1;
    end
  end

  assign bus.imem_address = r_pc;
  assign bus.instr        = r_instr;
  assign bus.instr_pc     = r_instr_pc;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.fetch_fault  = r_fetch_fault;
  assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes expected {instr, pc} into a
// scoreboard queue; a negedge monitor pops and compares on every accepted word.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_1000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_item_t;

  fetch_item_t sb_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_1000) return 32'h0050_0093;
    return {addr[15:0], 16'h0093};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) bus.imem_data_out <= mem_word(bus.imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake (valid && ready at the coming edge) must match the queue head.
  always @(negedge clk) begin
    if (!reset && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got instr %h pc %h expected none", bus.instr, bus.instr_pc);
      end else begin
        fetch_item_t e;
        e = sb_q.pop_front();
        check("sb_instr", bus.instr, e.word);
        check("sb_instr_pc", bus.instr_pc, e.pc);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    fetch_item_t e;
    e.word = mem_word(pc);
    e.pc   = pc;
    sb_q.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset              = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_data_out  = 32'h0;

    // Reset values
    #12;
    check("rst_addr", bus.imem_address, 32'h1000);
    check("rst_instr", bus.instr, 32'h0000_0013);
    check("rst_instr_pc", bus.instr_pc, 32'h1000);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);

    // First fetch: valid two edges after reset release
    sb_q.push_back('{word: 32'h0050_0093, pc: 32'h1000});
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t1_valid_wait", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t1_instr", bus.instr, 32'h0050_0093);
    check("t1_instr_pc", bus.instr_pc, 32'h1000);
    tick();
    check("t1_next_addr", bus.imem_address, 32'h1004);
    check("t1_count", bus.fetch_count, 32'd1);

    // Back-pressure: instr_ready low for 5 cycles in HOLD
    bus.instr_ready = 1'b0;
    expect_fetch(32'h1004);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("t2_hold_instr", bus.instr, 32'h1004_0093);
      check("t2_hold_pc", bus.instr_pc, 32'h1004);
      check("t2_hold_addr", bus.imem_address, 32'h1004);
      check("t2_hold_count", bus.fetch_count, 32'd1);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("t2_count", bus.fetch_count, 32'd2);
    check("t2_addr", bus.imem_address, 32'h1008);

    // Redirect during WAIT discards the in-flight word
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1040;
    expect_fetch(32'h1040);
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_addr", bus.imem_address, 32'h1040);
    check("t3_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick(2);
    check("t3_instr_pc", bus.instr_pc, 32'h1040);
    tick();
    check("t3_count", bus.fetch_count, 32'd3);

    // Accept and redirect in the same HOLD cycle
    bus.instr_ready = 1'b0;
    expect_fetch(32'h1044);
    tick(2);
    check("t4_valid", {31'd0, bus.instr_valid}, 32'd1);
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1100;
    tick();
    bus.redirect_valid = 1'b0;
    check("t4_count", bus.fetch_count, 32'd4);
    check("t4_addr", bus.imem_address, 32'h1100);
    check("t4_valid_clr", {31'd0, bus.instr_valid}, 32'd0);

    // Misaligned redirect locks into FAULT; later redirects are ignored
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1042;
    tick();
    bus.redirect_pc    = 32'h2000;
    tick();
    bus.redirect_valid = 1'b0;
    tick(3);
    check("t5_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("t5_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("t5_addr", bus.imem_address, 32'h1100);
    check("t5_count", bus.fetch_count, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    check("t5_rst_addr", bus.imem_address, 32'h1000);

    // Asynchronous reset while in HOLD
    @(negedge clk);
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    tick(2);
    check("t6_valid_hold", {31'd0, bus.instr_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("t6_async_addr", bus.imem_address, 32'h1000);

    // Counter wrap from all-ones
    expect_fetch(32'h1000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_count;
    check("t6_preset", bus.fetch_count, 32'hFFFF_FFFF);
    tick(3);
    check("t6_wrap", bus.fetch_count, 32'd0);
    check("t6_addr", bus.imem_address, 32'h1004);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
